// File: rtl/seq_decoder_if.sv
// Symbol/decode bundle for seq_decoder: the producer drives valid/value, the decoder returns status.
interface seq_decoder_if;
   logic       valid;
   logic [3:0] value;
   logic [2:0] position;
   logic       dir;
   logic       locked;
   logic       err;
   logic       dir_chg;
   logic [7:0] err_count;

   modport master (
      output valid, value,
      input  position, dir, locked, err, dir_chg, err_count
   );

   modport slave (
      input  valid, value,
      output position, dir, locked, err, dir_chg, err_count
   );
endinterface

// File: rtl/seq_decoder.sv
// Sequence decoder: tracks a cyclic 8-entry symbol table, locks onto a direction, flags errors.
// Define SEQ_DEC_ERRCNT_EN to build the saturating rejected-symbol counter behind err_count.
module seq_decoder (
   input logic           clk,
   input logic           rst,
   seq_decoder_if.slave  bus
);

   typedef enum logic [1:0] {
      StHunt,
      StSync,
      StLocked
   } state_e;

   state_e     state_q, state_d;
   logic [2:0] position_q, position_d;
   logic       dir_q, dir_d;
   logic       locked_q, locked_d;
   logic       err_q, err_d;
   logic       dir_chg_q, dir_chg_d;

   logic       sym_legal;
   logic [2:0] sym_idx;
   logic [2:0] idx_up;
   logic [2:0] idx_dn;
   logic [2:0] idx_fwd;
   logic [2:0] idx_rev;

   // Table lookup: symbol -> index, with the eight gaps flagged illegal.
   always_comb begin
      sym_legal = 1'b1;
      sym_idx   = 3'd0;
      case (bus.value)
         4'd4:    sym_idx = 3'd0;
         4'd8:    sym_idx = 3'd1;
         4'd12:   sym_idx = 3'd2;
         4'd0:    sym_idx = 3'd3;
         4'd3:    sym_idx = 3'd4;
         4'd7:    sym_idx = 3'd5;
         4'd11:   sym_idx = 3'd6;
         4'd15:   sym_idx = 3'd7;
         default: sym_legal = 1'b0;
      endcase
   end

   // 3-bit arithmetic gives the mod-8 wrap for free.
   assign idx_up  = position_q + 3'd1;
   assign idx_dn  = position_q - 3'd1;
   assign idx_fwd = dir_q ? idx_up : idx_dn;
   assign idx_rev = dir_q ? idx_dn : idx_up;

   always_comb begin
      state_d    = state_q;
      position_d = position_q;
      dir_d      = dir_q;
      err_d      = 1'b0;
      dir_chg_d  = 1'b0;

      if (bus.valid) begin
         unique case (state_q)
            StHunt: begin
               if (sym_legal) begin
                  position_d = sym_idx;
                  state_d    = StSync;
               end else begin
                  err_d = 1'b1;
               end
            end

            StSync: begin
               if (!sym_legal) begin
                  err_d   = 1'b1;
                  state_d = StHunt;
               end else if (sym_idx == idx_up) begin
                  dir_d      = 1'b1;
                  position_d = sym_idx;
                  state_d    = StLocked;
               end else if (sym_idx == idx_dn) begin
                  dir_d      = 1'b0;
                  position_d = sym_idx;
                  state_d    = StLocked;
               end else if (sym_idx != position_q) begin
                  err_d      = 1'b1;
                  position_d = sym_idx;
               end
            end

            StLocked: begin
               if (sym_legal && sym_idx == idx_fwd) begin
                  position_d = sym_idx;
               end else if (sym_legal && sym_idx == idx_rev) begin
                  position_d = sym_idx;
                  dir_d      = ~dir_q;
                  dir_chg_d  = 1'b1;
               end else if (!(sym_legal && sym_idx == position_q)) begin
                  // Loss of lock keeps the last good position/dir for observation.
                  err_d   = 1'b1;
                  state_d = StHunt;
               end
            end

            default: state_d = StHunt;
         endcase
      end

      locked_d = (state_d == StLocked);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StHunt;
         position_q <= 3'd0;
         dir_q      <= 1'b1;
         locked_q   <= 1'b0;
         err_q      <= 1'b0;
         dir_chg_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         position_q <= position_d;
         dir_q      <= dir_d;
         locked_q   <= locked_d;
         err_q      <= err_d;
         dir_chg_q  <= dir_chg_d;
      end
   end

`ifdef SEQ_DEC_ERRCNT_EN
   logic [7:0] err_count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         err_count_q <= 8'd0;
      end else if (err_d && (err_count_q != 8'hff)) begin
         err_count_q <= err_count_q + 8'd1;
      end
   end

   assign bus.err_count = err_count_q;
`else
   assign bus.err_count = 8'd0;
`endif

   assign bus.position = position_q;
   assign bus.dir      = dir_q;
   assign bus.locked   = locked_q;
   assign bus.err      = err_q;
   assign bus.dir_chg  = dir_chg_q;

endmodule

// File: tb/tb_seq_decoder.sv
// Self-checking bench for seq_decoder: directed scenarios plus random symbols against a table model.
module tb_seq_decoder;

   logic clk;
   logic rst;
   seq_decoder_if bus ();

   seq_decoder dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;

   logic [3:0] sym_tab [8] = '{4'd4, 4'd8, 4'd12, 4'd0, 4'd3, 4'd7, 4'd11, 4'd15};

   // Reference model: 0 = hunt, 1 = sync, 2 = locked.
   int   m_state;
   int   m_pos;
   bit   m_dir;
   bit   m_err;
   bit   m_chg;
   int   m_cnt;

   function automatic int sym_index(input logic [3:0] v);
      for (int i = 0; i < 8; i++) begin
         if (sym_tab[i] == v) return i;
      end
      return -1;
   endfunction

   task automatic model_update(input logic v, input logic [3:0] val, input logic r);
      int idx;
      int up;
      int dn;
      int fwd;
      int rev;
      if (r) begin
         m_state = 0; m_pos = 0; m_dir = 1'b1; m_err = 1'b0; m_chg = 1'b0; m_cnt = 0;
         return;
      end
      m_err = 1'b0;
      m_chg = 1'b0;
      if (!v) return;
      idx = sym_index(val);
      up  = (m_pos + 1) % 8;
      dn  = (m_pos + 7) % 8;
      fwd = m_dir ? up : dn;
      rev = m_dir ? dn : up;
      case (m_state)
         0: begin
            if (idx >= 0) begin m_pos = idx; m_state = 1; end
            else m_err = 1'b1;
         end
         1: begin
            if (idx < 0) begin m_err = 1'b1; m_state = 0; end
            else if (idx == up) begin m_dir = 1'b1; m_pos = idx; m_state = 2; end
            else if (idx == dn) begin m_dir = 1'b0; m_pos = idx; m_state = 2; end
            else if (idx != m_pos) begin m_err = 1'b1; m_pos = idx; end
         end
         default: begin
            if (idx >= 0 && idx == fwd) m_pos = idx;
            else if (idx >= 0 && idx == rev) begin m_pos = idx; m_dir = !m_dir; m_chg = 1'b1; end
            else if (!(idx >= 0 && idx == m_pos)) begin m_err = 1'b1; m_state = 0; end
         end
      endcase
`ifdef SEQ_DEC_ERRCNT_EN
      if (m_err && m_cnt < 255) m_cnt++;
`endif
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      check("position", {5'd0, bus.position}, 8'(m_pos));
      check("dir", {7'd0, bus.dir}, {7'd0, m_dir});
      check("locked", {7'd0, bus.locked}, {7'd0, (m_state == 2)});
      check("err", {7'd0, bus.err}, {7'd0, m_err});
      check("dir_chg", {7'd0, bus.dir_chg}, {7'd0, m_chg});
      check("err_count", bus.err_count, 8'(m_cnt));
      check("err_and_chg", {7'd0, bus.err & bus.dir_chg}, 8'd0);
   endtask

   task automatic step(input logic v, input logic [3:0] val, input logic r);
      @(negedge clk);
      bus.valid = v;
      bus.value = val;
      rst       = r;
      @(posedge clk);
      model_update(v, val, r);
      #1;
      check_model();
   endtask

   task automatic do_reset();
      step(1'b0, 4'd0, 1'b1);
      step(1'b0, 4'd0, 1'b0);
   endtask

   int        errs;
   logic      rv;
   logic [3:0] rval;
   logic      rr;

   initial begin
      rst       = 1'b1;
      bus.valid = 1'b0;
      bus.value = 4'd0;
      m_state = 0; m_pos = 0; m_dir = 1'b1; m_err = 1'b0; m_chg = 1'b0; m_cnt = 0;

      // Reset values
      step(1'b1, 4'd4, 1'b1);
      check("rst_position", {5'd0, bus.position}, 8'd0);
      check("rst_dir", {7'd0, bus.dir}, 8'd1);
      check("rst_locked", {7'd0, bus.locked}, 8'd0);
      check("rst_err_count", bus.err_count, 8'd0);
      step(1'b0, 4'd0, 1'b0);

      // Lock up via 4, 8, 12
      step(1'b1, 4'd4, 1'b0);
      check("up_sync_locked", {7'd0, bus.locked}, 8'd0);
      step(1'b1, 4'd8, 1'b0);
      check("up_locked", {7'd0, bus.locked}, 8'd1);
      check("up_dir", {7'd0, bus.dir}, 8'd1);
      step(1'b1, 4'd12, 1'b0);
      check("up_position", {5'd0, bus.position}, 8'd2);
      check("up_err", {7'd0, bus.err}, 8'd0);

      // Continue up through the 7 -> 0 wrap
      step(1'b1, 4'd0, 1'b0);
      step(1'b1, 4'd3, 1'b0);
      step(1'b1, 4'd7, 1'b0);
      step(1'b1, 4'd11, 1'b0);
      check("wrap_pos6", {5'd0, bus.position}, 8'd6);
      step(1'b1, 4'd15, 1'b0);
      check("wrap_pos7", {5'd0, bus.position}, 8'd7);
      step(1'b1, 4'd4, 1'b0);
      check("wrap_pos0", {5'd0, bus.position}, 8'd0);
      check("wrap_locked", {7'd0, bus.locked}, 8'd1);

      // Reversal at position 5
      do_reset();
      step(1'b1, 4'd3, 1'b0);
      step(1'b1, 4'd7, 1'b0);
      check("rev_pre_pos", {5'd0, bus.position}, 8'd5);
      step(1'b1, 4'd3, 1'b0);
      check("rev_dir", {7'd0, bus.dir}, 8'd0);
      check("rev_chg", {7'd0, bus.dir_chg}, 8'd1);
      check("rev_pos", {5'd0, bus.position}, 8'd4);
      step(1'b0, 4'd3, 1'b0);
      check("rev_chg_pulse", {7'd0, bus.dir_chg}, 8'd0);
      step(1'b1, 4'd0, 1'b0);
      check("rev_down_pos", {5'd0, bus.position}, 8'd3);

      // Loss of lock at position 2
      do_reset();
      step(1'b1, 4'd4, 1'b0);
      step(1'b1, 4'd8, 1'b0);
      step(1'b1, 4'd12, 1'b0);
      step(1'b1, 4'd7, 1'b0);
      check("lol_err", {7'd0, bus.err}, 8'd1);
      check("lol_locked", {7'd0, bus.locked}, 8'd0);
      check("lol_pos_hold", {5'd0, bus.position}, 8'd2);
`ifdef SEQ_DEC_ERRCNT_EN
      check("lol_err_count", bus.err_count, 8'd1);
`else
      check("lol_err_count", bus.err_count, 8'd0);
`endif
      step(1'b0, 4'd7, 1'b0);
      check("lol_err_pulse", {7'd0, bus.err}, 8'd0);

      // Reset mid-lock with a symbol present
      do_reset();
      step(1'b1, 4'd4, 1'b0);
      step(1'b1, 4'd8, 1'b0);
      check("mid_locked", {7'd0, bus.locked}, 8'd1);
      step(1'b1, 4'd15, 1'b1);
      check("mid_rst_locked", {7'd0, bus.locked}, 8'd0);
      check("mid_rst_position", {5'd0, bus.position}, 8'd0);
      check("mid_rst_dir", {7'd0, bus.dir}, 8'd1);
      step(1'b1, 4'd8, 1'b0);
      check("mid_relock_wait", {7'd0, bus.locked}, 8'd0);
      step(1'b1, 4'd12, 1'b0);
      check("mid_relock", {7'd0, bus.locked}, 8'd1);

      // 300 illegal symbols
      do_reset();
      errs = 0;
      for (int i = 0; i < 300; i++) begin
         step(1'b1, 4'd5, 1'b0);
         if (bus.err === 1'b1) errs++;
      end
      check("illegal_pulses", 8'(errs == 300), 8'd1);
`ifdef SEQ_DEC_ERRCNT_EN
      check("illegal_sat", bus.err_count, 8'd255);
`else
      check("illegal_sat", bus.err_count, 8'd0);
`endif

      // Randomized run biased toward neighbouring table entries
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         rv = ($urandom_range(0, 9) < 8);
         rr = ($urandom_range(0, 63) == 0);
         if ($urandom_range(0, 3) < 3) rval = sym_tab[(m_pos + $urandom_range(0, 2) + 7) % 8];
         else rval = 4'($urandom_range(0, 15));
         step(rv, rval, rr);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
